// File: rtl/bram_fifo_ctrl.sv
// Single-clock FIFO controller for an external simple dual-port BRAM.
// After reset it zero-fills the whole BRAM and then runs as a FIFO with RD_LAT-cycle read data.
module bram_fifo_ctrl #(
  parameter int DW     = 8,
  parameter int AW     = 6,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          rd_valid,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          busy,
  output logic          ovf,
  output logic          udf,
  input  logic          clr_err,
  output logic [DW-1:0] bram_di,
  output logic [AW-1:0] bram_wraddr,
  output logic          bram_wren,
  output logic          bram_we,
  output logic [AW-1:0] bram_rdaddr,
  output logic          bram_rden,
  output logic          bram_regce,
  output logic          bram_rst,
  input  logic [DW-1:0] bram_do,
  output logic [0:0]    dbg_state
);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam int unsigned DEPTH_I = 1 << AW;
  localparam logic [AW:0]   DEPTH   = DEPTH_I[AW:0];
  localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] init_addr_q, init_addr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic [1:0]    rd_pipe_q, rd_pipe_d;

  logic run;
  logic push_ok, pop_ok;
  logic push_err, pop_err;

  // Handshake: push/pop are single-cycle requests sampled every RUN cycle; a push is
  // accepted iff !full and a pop iff !empty (both may be accepted together); a refused
  // request is dropped and latched in ovf/udf. rd_valid qualifies dout for exactly one
  // cycle, RD_LAT cycles after each accepted pop; there is no back-pressure on dout.
  always_comb begin
    run      = (state_q == ST_RUN);
    full     = (count_q == DEPTH);
    empty    = (count_q == '0);
    push_ok  = run & push & ~full;
    pop_ok   = run & pop & ~empty;
    push_err = run & push & full;
    pop_err  = run & pop & empty;

    state_d     = state_q;
    init_addr_d = init_addr_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;

    if (state_q == ST_INIT) begin
      init_addr_d = init_addr_q + PTR_ONE;
      if (init_addr_q == '1) begin
        state_d = ST_RUN;
      end
    end else begin
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end

    // A new error outranks clr_err arriving in the same cycle.
    if (push_err) begin
      ovf_d = 1'b1;
    end else if (clr_err) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end

    if (pop_err) begin
      udf_d = 1'b1;
    end else if (clr_err) begin
      udf_d = 1'b0;
    end else begin
      udf_d = udf_q;
    end

    rd_pipe_d = {rd_pipe_q[0], pop_ok};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      init_addr_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
      rd_pipe_q   <= '0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
      rd_pipe_q   <= rd_pipe_d;
    end
  end

  // The sweep write enable is gated by rst_n so the BRAM sees no writes while reset is held.
  always_comb begin
    if (state_q == ST_INIT) begin
      bram_wren   = rst_n;
      bram_we     = rst_n;
      bram_wraddr = init_addr_q;
      bram_di     = '0;
    end else begin
      bram_wren   = push_ok;
      bram_we     = push_ok;
      bram_wraddr = wr_ptr_q;
      bram_di     = din;
    end
    bram_rdaddr = rd_ptr_q;
    bram_rden   = pop_ok;
    bram_rst    = 1'b0;
    if (RD_LAT == 2) begin
      bram_regce = rd_pipe_q[0];
      rd_valid   = rd_pipe_q[1];
    end else begin
      bram_regce = 1'b0;
      rd_valid   = rd_pipe_q[0];
    end
    dout      = bram_do;
    count     = count_q;
    busy      = (state_q == ST_INIT);
    ovf       = ovf_q;
    udf       = udf_q;
    dbg_state = state_q;
  end

endmodule

// File: doc/bram_fifo_ctrl.md
BRAM_FIFO_CTRL -- requirements
Module: bram_fifo_ctrl

Interface
REQ-001 Parameter DW, default 8, data width of the BRAM port in bits.
REQ-002 Parameter AW, default 6, BRAM address width; depth = 2**AW = 64.
REQ-003 Parameter RD_LAT, default 1, BRAM read latency; legal values 1 or 2 (2 = BRAM output register used).
REQ-004 clk  in  1  single clock; all logic on rising edge; drives BRAM RDCLK and WRCLK.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 push  in  1  write request; din  in  DW  write data.
REQ-007 pop  in  1  read request.
REQ-008 dout  out  DW  read data; rd_valid  out  1  dout qualifier.
REQ-009 full, empty  out  1 each  status; count  out  AW+1  occupancy.
REQ-010 busy  out  1  init sweep in progress; ovf, udf  out  1 each  sticky overflow/underflow; clr_err  in  1  clears ovf/udf.
REQ-011 bram_di  out  DW; bram_wraddr  out  AW; bram_wren  out  1; bram_we  out  1.
REQ-012 bram_rdaddr  out  AW; bram_rden  out  1; bram_regce  out  1; bram_rst  out  1; bram_do  in  DW.

Function
REQ-013 FSM has two states: INIT, RUN; rst_n low forces INIT.
REQ-014 INIT: one write per cycle of zero data to addresses 0..2**AW-1 in ascending order; busy=1; exits to RUN on the cycle after address 2**AW-1 is written (64 cycles).
REQ-015 In INIT, push/pop are ignored: no pointer change, no ovf/udf, rd_valid=0.
REQ-016 In RUN, push is accepted iff !full; pop is accepted iff !empty; both may be accepted in the same cycle.
REQ-017 Accepted push: same cycle bram_wren=bram_we=1, bram_wraddr=wr_ptr, bram_di=din (combinational); wr_ptr increments at the edge.
REQ-018 Accepted pop: same cycle bram_rden=1, bram_rdaddr=rd_ptr; rd_ptr increments at the edge.
REQ-019 Pointers are AW bits and wrap 2**AW-1 -> 0.
REQ-020 count: +1 on push only, -1 on pop only, unchanged on both or neither; range 0..2**AW.
REQ-021 empty = (count==0); full = (count==2**AW); both registered-state derived, valid every cycle.
REQ-022 rd_valid pulses exactly RD_LAT cycles after the accepted pop cycle, one pulse per pop; dout = bram_do in that cycle.
REQ-023 RD_LAT=1: bram_regce=0 constantly; RD_LAT=2: bram_regce=1 in the cycle after an accepted pop, else 0.
REQ-024 Back-to-back pops sustain one read per cycle with no bubbles.
REQ-025 Push when full (RUN) is dropped and sets ovf; pop when empty (RUN) is dropped and sets udf.
REQ-026 clr_err clears ovf/udf at the next edge; a new error in the same cycle takes priority (flag stays 1).
REQ-027 Push+pop while full: pop accepted, push rejected, ovf set; push+pop while empty: push accepted, pop rejected, udf set.
REQ-028 bram_rst = 0 always; the zeroing sweep replaces BRAM reset.

Reset
REQ-029 While rst_n=0: state=INIT, wr_ptr=rd_ptr=0, init address=0, count=0, empty=1, full=0, busy=1, ovf=udf=0, rd_valid=0 and read pipeline cleared, bram_wren=bram_we=bram_rden=bram_regce=0.
REQ-030 Reset asserted mid-operation discards all in-flight reads (no rd_valid emitted afterwards) and restarts the INIT sweep on release.

Verification
REQ-031 Release reset -> busy=1 for exactly 64 cycles, bram_wraddr steps 0..63 with bram_di=0, then busy=0, empty=1, count=0.
REQ-032 Push 0x11,0x22,0x33 then pop 3x back-to-back (RD_LAT=1) -> rd_valid on 3 consecutive cycles, one cycle after each pop, with dout 0x11,0x22,0x33; empty=1 after.
REQ-033 Fill with 64 pushes -> full=1, count=64; 65th push -> ovf=1, count stays 64; clr_err -> ovf=0.
REQ-034 Pop on empty FIFO -> udf=1, no bram_rden, no rd_valid; simultaneous push+pop when empty -> count=1, udf=1.
REQ-035 Wrap-around: 100 interleaved push/pop of incrementing data at count~10 -> pointers wrap 63->0, output sequence intact; RD_LAT=2 run -> rd_valid 2 cycles after each pop with bram_regce 1 cycle after.
REQ-036 Assert rst_n=0 one cycle after a pop with RD_LAT=2 -> no rd_valid pulse; count=0 and INIT sweep restarts after release.
